// File: rtl/line_queue_renderer.sv
// -----------------------------------------------------------------------------
// line_queue_renderer
//
// Accepts line segments through a small FIFO (valid/ready) and rasterises each
// one with Bresenham's algorithm at one pixel per clock into an internal 1-bit
// frame buffer. Each line either sets its pixels or erases them. Pixels that
// fall outside the frame buffer still take their cycle but are not written.
// A registered read port, addressed by the VGA h/v counters, returns the
// buffer bit one clock later. The whole buffer is cleared after reset and on
// request; queued lines survive a clear and are drawn after it.
//
// Ports
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_x0, i_y0, i_x1, i_y1     line endpoints (unsigned, COORD_W bits)
//   i_line_erase               1: line writes 0, 0: line writes 1
//   i_line_valid/o_line_ready  push handshake into the line FIFO
//   i_clear_buffer             one-cycle request to zero the whole buffer
//   i_hcounter, i_vcounter     read coordinates
//   o_pixel_on                 buffer bit at (h,v), one cycle latency
//   o_waiting                  idle: FIFO empty, no clear pending, not drawing
// -----------------------------------------------------------------------------
module line_queue_renderer #(
   parameter int COORD_W = 11,
   parameter int FB_W    = 64,
   parameter int FB_H    = 48,
   parameter int QUEUE_D = 4
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [COORD_W-1:0] i_x0,
   input  logic [COORD_W-1:0] i_y0,
   input  logic [COORD_W-1:0] i_x1,
   input  logic [COORD_W-1:0] i_y1,
   input  logic               i_line_erase,
   input  logic               i_line_valid,
   output logic               o_line_ready,
   input  logic               i_clear_buffer,
   input  logic [COORD_W-1:0] i_hcounter,
   input  logic [COORD_W-1:0] i_vcounter,
   output logic               o_pixel_on,
   output logic               o_waiting
);

   localparam int FB_SIZE = FB_W * FB_H;
   localparam int ADDR_W  = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
   localparam int PTR_W   = $clog2(QUEUE_D);
   // Error term: one sign bit plus one bit of headroom over a coordinate.
   localparam int ERR_W   = COORD_W + 2;

   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FB_SIZE - 1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]     CNT_FULL  = (PTR_W + 1)'(QUEUE_D);
   localparam logic [COORD_W:0]   X_LIMIT   = (COORD_W + 1)'(FB_W);
   localparam logic [COORD_W:0]   Y_LIMIT   = (COORD_W + 1)'(FB_H);
   localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] y1;
      logic               erase;
   } line_t;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOAD,
      ST_DRAW
   } state_t;

   // ---------------------------------------------------------------- signals
   state_t state, state_next;

   line_t            fifo_mem [QUEUE_D];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   fifo_count;
   logic             fifo_empty, fifo_full;
   logic             push, pop;

   logic             clear_pend;
   logic [ADDR_W-1:0] clr_addr;

   line_t               cur;
   logic [COORD_W-1:0]  px, py;
   logic                x_neg, y_neg;
   logic signed [ERR_W-1:0] dx, dy, err, err_next;
   logic signed [ERR_W:0]   e2, dx_ext, dy_ext;
   logic [COORD_W-1:0]  dx_abs, dy_abs;
   logic                step_x, step_y, at_end;

   logic                plot_in_range;
   logic [ADDR_W-1:0]   plot_addr;
   logic                rd_in_range;
   logic [ADDR_W-1:0]   rd_addr;

   logic                fb [FB_SIZE];
   logic                fb_we;
   logic [ADDR_W-1:0]   fb_waddr;
   logic                fb_wdata;

   // ------------------------------------------------------------- line FIFO
   assign fifo_empty   = (fifo_count == '0);
   assign fifo_full    = (fifo_count == CNT_FULL);
   // The buffer is unusable while being cleared, so no new lines are taken.
   assign o_line_ready = !fifo_full && (state != ST_CLEAR);
   assign push         = i_line_valid && o_line_ready;
   // A pending clear always goes ahead of the next queued line.
   assign pop          = (state == ST_IDLE) && !clear_pend && !fifo_empty;

   // NOTE: storage arrays are deliberately left out of reset; the pointers and
   // count alone decide which entries are valid.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{x0: i_x0, y0: i_y0, x1: i_x1, y1: i_y1,
                               erase: i_line_erase};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------ clear control
   // A request is remembered in any state; IDLE consumes it when it enters
   // CLEAR. A request arriving during CLEAR therefore buys one more full pass.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         clear_pend <= 1'b0;
      end else begin
         clear_pend <= i_clear_buffer || (clear_pend && (state != ST_IDLE));
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         clr_addr <= '0;
      end else if (state == ST_CLEAR) begin
         clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + ADDR_ONE;
      end
   end

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_CLEAR;
      else            state <= state_next;
   end

   // NOTE: the default assignment at the top keeps this block free of latches.
   always_comb begin
      state_next = state;
      case (state)
         ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_IDLE;
         ST_IDLE: begin
            if (clear_pend)       state_next = ST_CLEAR;
            else if (!fifo_empty) state_next = ST_LOAD;
         end
         ST_LOAD:  state_next = ST_DRAW;
         ST_DRAW:  if (at_end) state_next = ST_IDLE;
         default:  state_next = ST_CLEAR;
      endcase
   end

   // --------------------------------------------------------- Bresenham core
   assign dx_abs = (cur.x1 >= cur.x0) ? (cur.x1 - cur.x0) : (cur.x0 - cur.x1);
   assign dy_abs = (cur.y1 >= cur.y0) ? (cur.y1 - cur.y0) : (cur.y0 - cur.y1);

   // Doubling is an exact left shift in one extra bit; the compare operands are
   // sign-extended to the same width.
   assign e2     = {err, 1'b0};
   assign dx_ext = {dx[ERR_W-1], dx};
   assign dy_ext = {dy[ERR_W-1], dy};
   assign step_x = (e2 >= dy_ext);
   assign step_y = (e2 <= dx_ext);
   assign at_end = (px == cur.x1) && (py == cur.y1);

   always_comb begin
      err_next = err;
      if (step_x) err_next = err_next + dy;
      if (step_y) err_next = err_next + dx;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cur   <= '0;
         px    <= '0;
         py    <= '0;
         x_neg <= 1'b0;
         y_neg <= 1'b0;
         dx    <= '0;
         dy    <= '0;
         err   <= '0;
      end else begin
         if (pop) cur <= fifo_mem[rd_ptr];

         if (state == ST_LOAD) begin
            dx    <= $signed({2'b00, dx_abs});
            dy    <= -$signed({2'b00, dy_abs});
            err   <= $signed({2'b00, dx_abs}) - $signed({2'b00, dy_abs});
            x_neg <= (cur.x1 < cur.x0);
            y_neg <= (cur.y1 < cur.y0);
            px    <= cur.x0;
            py    <= cur.y0;
         end else if ((state == ST_DRAW) && !at_end) begin
            err <= err_next;
            if (step_x) px <= x_neg ? (px - COORD_ONE) : (px + COORD_ONE);
            if (step_y) py <= y_neg ? (py - COORD_ONE) : (py + COORD_ONE);
         end
      end
   end

   // ------------------------------------------------------------ frame buffer
   // Clipping happens before address formation so an off-screen x never folds
   // into the next row.
   assign plot_in_range = ({1'b0, px} < X_LIMIT) && ({1'b0, py} < Y_LIMIT);
   assign plot_addr     = ADDR_W'(py * FB_W + px);

   assign fb_we    = (state == ST_CLEAR) || ((state == ST_DRAW) && plot_in_range);
   assign fb_waddr = (state == ST_CLEAR) ? clr_addr : plot_addr;
   assign fb_wdata = (state == ST_CLEAR) ? 1'b0 : !cur.erase;

   always_ff @(posedge i_clk) begin
      if (fb_we) fb[fb_waddr] <= fb_wdata;
   end

   // --------------------------------------------------------------- read port
   // The read samples the array before this edge's write lands, so a
   // same-address read/write returns the old bit.
   assign rd_in_range = ({1'b0, i_hcounter} < X_LIMIT) && ({1'b0, i_vcounter} < Y_LIMIT);
   assign rd_addr     = ADDR_W'(i_vcounter * FB_W + i_hcounter);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_pixel_on <= 1'b0;
         o_waiting  <= 1'b0;
      end else begin
         o_pixel_on <= rd_in_range ? fb[rd_addr] : 1'b0;
         o_waiting  <= (state == ST_IDLE) && fifo_empty && !clear_pend;
      end
   end

endmodule

// File: tb/tb_line_queue_renderer.sv
// -----------------------------------------------------------------------------
// tb_line_queue_renderer
//
// Directed bench for line_queue_renderer (64x48 buffer, 4-deep FIFO). A
// reference frame buffer is kept as a plain 2-D bit array and updated by a
// straightforward integer Bresenham walk for every line pushed. While the DUT
// is idle the bench sweeps the read counters over the whole buffer plus an
// out-of-range margin, and a compare process checks every returned pixel
// against the reference. Literal reads and literal pixel/cycle counts pin the
// reference model itself.
// -----------------------------------------------------------------------------
module tb_line_queue_renderer;

   localparam int COORD_W = 11;
   localparam int FB_W    = 64;
   localparam int FB_H    = 48;
   localparam int QUEUE_D = 4;
   localparam int LIMIT   = 20000;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic               line_erase = 1'b0;
   logic               line_valid = 1'b0;
   logic               line_ready;
   logic               clear_buffer = 1'b0;
   logic [COORD_W-1:0] hcnt = '0, vcnt = '0;
   logic               pixel_on;
   logic               waiting;

   int n_checks = 0;
   int n_pass   = 0;

   bit   model_fb [FB_H][FB_W];
   logic scan_en = 1'b0;
   int   cap_h, cap_v;
   logic cap_en;

   always #5 clk = ~clk;

   line_queue_renderer #(
      .COORD_W(COORD_W), .FB_W(FB_W), .FB_H(FB_H), .QUEUE_D(QUEUE_D)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_x0          (x0),
      .i_y0          (y0),
      .i_x1          (x1),
      .i_y1          (y1),
      .i_line_erase  (line_erase),
      .i_line_valid  (line_valid),
      .o_line_ready  (line_ready),
      .i_clear_buffer(clear_buffer),
      .i_hcounter    (hcnt),
      .i_vcounter    (vcnt),
      .o_pixel_on    (pixel_on),
      .o_waiting     (waiting)
   );

   // ------------------------------------------------------------- utilities
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int model_pix(input int h, input int v);
      if (h >= 0 && h < FB_W && v >= 0 && v < FB_H) return int'(model_fb[v][h]);
      return 0;
   endfunction

   task automatic model_clear();
      for (int v = 0; v < FB_H; v++)
         for (int h = 0; h < FB_W; h++)
            model_fb[v][h] = 1'b0;
   endtask

   // Integer Bresenham walk; returns the number of pixels visited.
   task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                             input bit er, output int npix);
      int dx, dy, sx, sy, err, e2, x, y;
      dx   = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy   = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx   = (ax0 < ax1) ? 1 : -1;
      sy   = (ay0 < ay1) ? 1 : -1;
      err  = dx + dy;
      x    = ax0;
      y    = ay0;
      npix = 0;
      for (int k = 0; k < 5000; k++) begin
         if (x >= 0 && x < FB_W && y >= 0 && y < FB_H) model_fb[y][x] = !er;
         npix++;
         if (x == ax1 && y == ay1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endtask

   // ------------------------------------------------------ compare process
   // Captures the read address on each rising edge and checks the registered
   // pixel one time unit later against the reference buffer.
   always @(posedge clk) begin
      cap_h  = int'(hcnt);
      cap_v  = int'(vcnt);
      cap_en = scan_en;
      #1;
      if (cap_en === 1'b1)
         check($sformatf("scan h=%0d v=%0d", cap_h, cap_v), int'(pixel_on),
               model_pix(cap_h, cap_v));
   end

   // ------------------------------------------------------------- stimulus
   // All tasks start and end just after a falling edge.
   task automatic push_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input bit er);
      int waited = 0;
      x0 = COORD_W'(ax0); y0 = COORD_W'(ay0);
      x1 = COORD_W'(ax1); y1 = COORD_W'(ay1);
      line_erase = er;
      line_valid = 1'b1;
      while (!line_ready && waited < LIMIT) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= LIMIT) check("push ready timeout", int'(line_ready), 1);
      @(negedge clk);
      line_valid = 1'b0;
   endtask

   // Counts the cycles o_waiting stays low after a push into an idle DUT.
   task automatic measure_busy(output int low);
      int guard = 0;
      while (waiting && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      low = 0;
      while (!waiting && low < LIMIT) begin
         low++;
         @(negedge clk);
      end
      if (low >= LIMIT) check("busy timeout", int'(waiting), 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!waiting && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check(name, int'(waiting), 1);
   endtask

   task automatic draw_one(input string name, input int ax0, input int ay0, input int ax1,
                           input int ay1, input bit er, input int exp_pix);
      int low, npix;
      push_line(ax0, ay0, ax1, ay1, er);
      measure_busy(low);
      model_line(ax0, ay0, ax1, ay1, er, npix);
      check({name, " pixel count"}, npix, exp_pix);
      check({name, " busy cycles"}, low, npix + 2);
   endtask

   task automatic read_pix(input string name, input int h, input int v, input int exp);
      hcnt = COORD_W'(h);
      vcnt = COORD_W'(v);
      @(negedge clk);
      check(name, int'(pixel_on), exp);
   endtask

   task automatic scan();
      scan_en = 1'b1;
      for (int v = 0; v < FB_H + 2; v++)
         for (int h = 0; h < FB_W + 8; h++) begin
            hcnt = COORD_W'(h);
            vcnt = COORD_W'(v);
            @(negedge clk);
         end
      scan_en = 1'b0;
   endtask

   // Releases reset and checks the initial clear length and handshake.
   task automatic release_and_clear(input string name);
      int cnt = 0;
      rst_n = 1'b1;
      while (!waiting && cnt < LIMIT) begin
         @(negedge clk);
         cnt++;
         if (cnt == 100) check({name, " ready low in clear"}, int'(line_ready), 0);
      end
      check({name, " clear cycles"}, cnt, 3073);
      check({name, " ready after clear"}, int'(line_ready), 1);
      model_clear();
   endtask

   initial begin
      int n;
      model_clear();

      // 1: reset state and the initial full clear
      repeat (3) @(negedge clk);
      check("reset waiting", int'(waiting), 0);
      check("reset ready", int'(line_ready), 0);
      check("reset pixel", int'(pixel_on), 0);
      release_and_clear("t1");
      scan();

      // 2: diagonal (0,0)-(3,3)
      draw_one("t2", 0, 0, 3, 3, 1'b0, 4);
      check("t2 busy literal", model_pix(3, 3), 1);
      read_pix("t2 (1,1)", 1, 1, 1);
      read_pix("t2 (3,3)", 3, 3, 1);
      read_pix("t2 (1,0)", 1, 0, 0);
      read_pix("t2 (4,4)", 4, 4, 0);
      scan();

      // 3: shallow line drawn right-to-left, then erased
      draw_one("t3 draw", 10, 5, 2, 1, 1'b0, 9);
      read_pix("t3 (8,4)", 8, 4, 1);
      read_pix("t3 (2,1)", 2, 1, 1);
      read_pix("t3 (9,5)", 9, 5, 0);
      scan();
      draw_one("t3 erase", 10, 5, 2, 1, 1'b1, 9);
      read_pix("t3 erased (8,4)", 8, 4, 0);
      read_pix("t3 erased (10,5)", 10, 5, 0);
      scan();

      // 4: five lines back-to-back; later erases depend on drawing order
      push_line(0, 10, 40, 10, 1'b0);
      push_line(0, 12, 10, 12, 1'b0);
      push_line(5, 14, 5, 20, 1'b0);
      push_line(0, 10, 20, 10, 1'b1);
      push_line(5, 16, 5, 18, 1'b1);
      check("t4 ready low when full", int'(line_ready), 0);
      wait_idle("t4 idle timeout");
      model_line(0, 10, 40, 10, 1'b0, n);
      model_line(0, 12, 10, 12, 1'b0, n);
      model_line(5, 14, 5, 20, 1'b0, n);
      model_line(0, 10, 20, 10, 1'b1, n);
      model_line(5, 16, 5, 18, 1'b1, n);
      read_pix("t4 (30,10)", 30, 10, 1);
      read_pix("t4 (15,10)", 15, 10, 0);
      read_pix("t4 (5,17)", 5, 17, 0);
      read_pix("t4 (5,15)", 5, 15, 1);
      read_pix("t4 (10,12)", 10, 12, 1);
      scan();

      // 5: line running off the right edge
      draw_one("t5", 60, 40, 70, 40, 1'b0, 11);
      read_pix("t5 (63,40)", 63, 40, 1);
      read_pix("t5 (70,40)", 70, 40, 0);
      read_pix("t5 (0,41)", 0, 41, 0);
      read_pix("t5 (0,40)", 0, 40, 0);
      scan();

      // 6: clear requested mid-line with two lines queued
      push_line(0, 30, 50, 30, 1'b0);
      push_line(0, 32, 5, 37, 1'b0);
      push_line(10, 33, 20, 33, 1'b0);
      repeat (8) @(negedge clk);
      clear_buffer = 1'b1;
      @(negedge clk);
      clear_buffer = 1'b0;
      n = 0;
      while (line_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t6 ready low during clear", int'(line_ready), 0);
      wait_idle("t6 idle timeout");
      model_line(0, 30, 50, 30, 1'b0, n);
      model_clear();
      model_line(0, 32, 5, 37, 1'b0, n);
      model_line(10, 33, 20, 33, 1'b0, n);
      read_pix("t6 (40,30)", 40, 30, 0);
      read_pix("t6 (30,10)", 30, 10, 0);
      read_pix("t6 (0,32)", 0, 32, 1);
      read_pix("t6 (5,37)", 5, 37, 1);
      read_pix("t6 (15,33)", 15, 33, 1);
      scan();

      // 7: reset in the middle of a line; nothing resumes afterwards
      push_line(0, 0, 63, 47, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t7 reset waiting", int'(waiting), 0);
      check("t7 reset ready", int'(line_ready), 0);
      check("t7 reset pixel", int'(pixel_on), 0);
      @(negedge clk);
      release_and_clear("t7");
      repeat (5) @(negedge clk);
      check("t7 still idle", int'(waiting), 1);
      scan();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
